// File: rtl/gcd_arbiter_ctrl_pkg.sv
// Shared types and constants for the two-requester GCD controller.
// State encodings, requester IDs and the default operand width.
package gcd_arbiter_ctrl_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_e;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

endpackage

// File: rtl/gcd_arbiter_ctrl_if.sv
// Request/operand/result bundle between the operand sources and the GCD block.
// master drives requests and operands; slave is the GCD controller.
interface gcd_arbiter_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  ack0, ack1, busy, done, done_id, result
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output ack0, ack1, busy, done, done_id, result
    );

endinterface

// File: rtl/gcd_arbiter_ctrl_datapath.sv
// Subtractive GCD datapath: x/y registers, comparator and subtractor.
// A zero operand loads both registers with a|b so the loop ends at once.
module gcd_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic [WIDTH-1:0] x
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             has_zero;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        has_zero = (a == '0) || (b == '0);
        if (load) begin
            if (has_zero) begin
                x_d = a | b;
                y_d = a | b;
            end else begin
                x_d = a;
                y_d = b;
            end
        end else if (step) begin
            // larger operand is always the minuend, so no wrap
            if (x_q > y_q) begin
                x_d = x_q - y_q;
            end else if (y_q > x_q) begin
                y_d = y_q - x_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign eq = (x_q == y_q);
    assign x  = x_q;

endmodule

// File: rtl/gcd_arbiter_ctrl.sv
// Round-robin arbiter and FSM sharing one GCD datapath between two requesters.
// Result is returned with a one-cycle done pulse tagged with the owner ID.
module gcd_arbiter_ctrl
    import gcd_arbiter_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic               clk,
    input logic               rst_n,
    gcd_arbiter_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             cur_id_q, cur_id_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             gnt0, gnt1;
    logic             idle;
    logic             ack0, ack1;
    logic             load;
    logic             step;
    logic             gnt_id;
    logic [WIDTH-1:0] ld_a, ld_b;
    logic             eq;
    logic [WIDTH-1:0] x;

    always_comb begin
        // on a tie, the requester not served last wins
        gnt1   = bus.req1 & (~bus.req0 | (last_grant_q == ID0));
        gnt0   = bus.req0 & ~gnt1;
        idle   = (state_q == S_IDLE);
        ack0   = idle & gnt0;
        ack1   = idle & gnt1;
        load   = ack0 | ack1;
        gnt_id = ack1 ? ID1 : ID0;
        ld_a   = ack1 ? bus.a1 : bus.a0;
        ld_b   = ack1 ? bus.b1 : bus.b0;
        step   = (state_q == S_CALC) & ~eq;
    end

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .a     (ld_a),
        .b     (ld_b),
        .eq    (eq),
        .x     (x)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        result_d     = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    last_grant_d = gnt_id;
                    cur_id_d     = gnt_id;
                    state_d      = S_CALC;
                end
            end
            S_CALC: begin
                if (eq) begin
                    result_d  = x;
                    done_d    = 1'b1;
                    done_id_d = cur_id_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID1;
            cur_id_q     <= ID0;
            done_q       <= 1'b0;
            done_id_q    <= ID0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            result_q     <= result_d;
        end
    end

    assign bus.ack0    = ack0;
    assign bus.ack1    = ack1;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;

endmodule

// File: tb/tb_gcd_arbiter_ctrl.sv
// Directed bench for gcd_arbiter_ctrl: arbitration, latency, zero operands,
// worst case and mid-calculation reset, all with hand-computed expectations.
module tb_gcd_arbiter_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gcd_arbiter_ctrl_if #(.WIDTH(8)) bus ();

    gcd_arbiter_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc, output int bcnt,
                             output bit seen);
        cyc  = 0;
        bcnt = 1;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) bcnt++;
        end
    endtask

    task automatic run_job(input string tag, input bit id,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] er, input int el);
        int cyc;
        int bcnt;
        bit seen;
        @(negedge clk);
        if (id) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b;
        end
        #1;
        chk({tag, ".ack_own"}, id ? bus.ack1 : bus.ack0, 1);
        chk({tag, ".ack_other"}, id ? bus.ack0 : bus.ack1, 0);
        @(posedge clk);
        #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = 8'hAA; bus.b0 = 8'h55;
        bus.a1 = 8'hAA; bus.b1 = 8'h55;
        chk({tag, ".busy_start"}, bus.busy, 1);
        wait_done(cyc, bcnt, seen);
        chk({tag, ".done_seen"}, seen, 1);
        chk({tag, ".latency"}, cyc, el);
        chk({tag, ".busy_cycles"}, bcnt, el);
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".done_id"}, bus.done_id, id);
        chk({tag, ".busy_end"}, bus.busy, 0);
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, bus.done, 0);
        chk({tag, ".result_hold"}, bus.result, er);
    endtask

    initial begin
        int  cyc;
        int  bcnt;
        bit  seen;
        int  ndone;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        #12;
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.result", bus.result, 0);
        chk("rst.done_id", bus.done_id, 0);
        chk("rst.ack0", bus.ack0, 0);
        chk("rst.ack1", bus.ack1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job("r0_10_5", 1'b0, 8'd10, 8'd5, 8'd5, 2);
        run_job("r1_12_8", 1'b1, 8'd12, 8'd8, 8'd4, 3);

        // simultaneous requests: 0 served first, then 1 right after
        @(negedge clk);
        bus.req0 = 1'b1; bus.a0 = 8'd10; bus.b0 = 8'd5;
        bus.req1 = 1'b1; bus.a1 = 8'd12; bus.b1 = 8'd8;
        #1;
        chk("tie.ack0", bus.ack0, 1);
        chk("tie.ack1", bus.ack1, 0);
        @(posedge clk);
        #1;
        bus.req0 = 1'b0; bus.a0 = 8'd0;
        chk("tie.ack1_busy", bus.ack1, 0);
        wait_done(cyc, bcnt, seen);
        chk("tie.j0_seen", seen, 1);
        chk("tie.j0_lat", cyc, 2);
        chk("tie.j0_result", bus.result, 5);
        chk("tie.j0_id", bus.done_id, 0);
        chk("tie.j1_ack1", bus.ack1, 1);
        chk("tie.j1_ack0", bus.ack0, 0);
        @(posedge clk);
        #1;
        bus.req1 = 1'b0; bus.a1 = 8'd0;
        chk("tie.j1_busy", bus.busy, 1);
        chk("tie.j1_nodone", bus.done, 0);
        wait_done(cyc, bcnt, seen);
        chk("tie.j1_seen", seen, 1);
        chk("tie.j1_lat", cyc, 3);
        chk("tie.j1_result", bus.result, 4);
        chk("tie.j1_id", bus.done_id, 1);

        run_job("z_0_9", 1'b0, 8'd0, 8'd9, 8'd9, 1);
        run_job("z_0_0", 1'b1, 8'd0, 8'd0, 8'd0, 1);
        run_job("z_7_0", 1'b0, 8'd7, 8'd0, 8'd7, 1);
        run_job("eq_6_6", 1'b1, 8'd6, 8'd6, 8'd6, 1);
        run_job("worst", 1'b0, 8'd255, 8'd1, 8'd1, 255);

        // reset in the middle of a long job
        @(negedge clk);
        bus.req0 = 1'b1; bus.a0 = 8'd255; bus.b0 = 8'd1;
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.req1 = 1'b1; bus.a1 = 8'd3; bus.b1 = 8'd3;
        chk("mid.ack1_ignored", bus.ack1, 0);
        chk("mid.busy", bus.busy, 1);
        @(negedge clk);
        bus.req1 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mid.busy_pre", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst.busy", bus.busy, 0);
        chk("arst.result", bus.result, 0);
        chk("arst.done", bus.done, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("arst.no_done", ndone, 0);
        chk("arst.idle", bus.busy, 0);
        run_job("post_rst", 1'b0, 8'd10, 8'd5, 8'd5, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
